// File: rtl/instr_prefetch.sv
// instr_prefetch: credit-based instruction fetch stage ahead of a small
// circular FIFO. Issues word-aligned requests, pushes in-order responses.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   redirect_en_i, redirect_pc_i   flush FIFO and restart at new PC
//   imem_req_o, imem_addr_o        fetch request / word address
//   imem_gnt_i                     request accepted on req && gnt
//   imem_rvalid_i, imem_rdata_i    in-order response
//   fifo_push_o, fifo_data_o       FIFO write port (combinational)
//   fifo_flush_o                   FIFO clear (combinational)
//   fifo_pop_i                     consumer pop, mirrored into occupancy
//   fetch_pc_o                     address of next request to issue

module instr_prefetch #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     FIFO_SIZE = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_en_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            fifo_push_o,
    output logic [XLEN-1:0] fifo_data_o,
    output logic            fifo_flush_o,
    input  logic            fifo_pop_i,
    output logic [XLEN-1:0] fetch_pc_o
);

    localparam int unsigned CW  = $clog2(FIFO_SIZE + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(FIFO_SIZE);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   live_q, live_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW:0] occ_live;
    logic [CW:0] live_drop;
    logic        credit_ok;
    logic        gnt;
    logic        rsp_drop;
    logic        rsp_push;
    logic        pop;
    logic        rsp_stale;
    logic        unused_pc_lsb;

    // Alignment bits of the redirect target are discarded.
    assign unused_pc_lsb = ^redirect_pc_i[1:0];

    assign imem_addr_o = pc_q;
    assign fetch_pc_o  = pc_q;
    assign fifo_data_o = imem_rdata_i;

    always_comb begin
        occ_live  = {1'b0, occ_q} + {1'b0, live_q};
        live_drop = {1'b0, live_q} + {1'b0, drop_q};
        // One credit check for FIFO space, one for the memory-side
        // outstanding cap (which includes responses we will discard).
        credit_ok = (occ_live < CAP) && (live_drop < CAP);

        imem_req_o   = rst_ni && !redirect_en_i && credit_ok;
        gnt          = imem_req_o && imem_gnt_i;
        fifo_flush_o = rst_ni && redirect_en_i;

        rsp_drop = imem_rvalid_i && (drop_q != '0);
        rsp_push = rst_ni && !redirect_en_i && imem_rvalid_i
                   && (drop_q == '0) && (live_q != '0);
        fifo_push_o = rsp_push;

        pop = !redirect_en_i && fifo_pop_i && (occ_q != '0);

        // A response in the redirect cycle retires one tracked request,
        // unless nothing was outstanding (protocol error, ignored).
        rsp_stale = imem_rvalid_i && (live_drop != '0);

        pc_d   = pc_q;
        occ_d  = occ_q;
        live_d = live_q;
        drop_d = drop_q;

        if (redirect_en_i) begin
            pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
            occ_d  = '0;
            live_d = '0;
            drop_d = drop_q + live_q - CW'(rsp_stale);
        end else begin
            if (gnt) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            live_d = live_q + CW'(gnt) - CW'(rsp_push);
            occ_d  = occ_q + CW'(rsp_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            occ_q  <= '0;
            live_q <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            occ_q  <= occ_d;
            live_q <= live_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed stimulus with a memory model and a
// scoreboard of expected FIFO pushes checked by a separate monitor.

module tb_instr_prefetch;

    localparam int          FS    = 4;
    localparam logic [31:0] RSTPC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        redirect_en_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        fifo_push_o;
    logic [31:0] fifo_data_o;
    logic        fifo_flush_o;
    logic        fifo_pop_i;
    logic [31:0] fetch_pc_o;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          lat    = 1;
    int          n_gnt  = 0;
    int          n_push = 0;
    int          occ_m  = 0;
    int          g0, p0;
    bit          rv_real  = 1'b0;
    bit          force_rv = 1'b0;
    bit          pop_ok;
    logic [31:0] exp_pc = RSTPC;
    logic [31:0] exp_w;
    logic [31:0] exp_q[$];
    req_t        pending[$];
    req_t        tmp_r;

    instr_prefetch #(
        .XLEN      (32),
        .FIFO_SIZE (FS),
        .RESET_PC  (RSTPC)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .redirect_en_i (redirect_en_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .fifo_push_o   (fifo_push_o),
        .fifo_data_o   (fifo_data_o),
        .fifo_flush_o  (fifo_flush_o),
        .fifo_pop_i    (fifo_pop_i),
        .fetch_pc_o    (fetch_pc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Memory model: in-order responses, each due lat cycles after grant.
    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            rv_real = rst_ni && (pending.size() > 0)
                      && (pending[0].due <= cyc);
            imem_rvalid_i = rv_real || force_rv;
            if (rv_real)
                imem_rdata_i = mem_word(pending[0].addr);
            else if (force_rv)
                imem_rdata_i = 32'hBAD0_BAD0;
            else
                imem_rdata_i = 32'h0;
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                pending.delete();
                exp_q.delete();
                exp_pc = RSTPC;
                occ_m  = 0;
            end else begin
                if (rv_real && pending.size() > 0)
                    tmp_r = pending.pop_front();
                if (redirect_en_i) begin
                    chk("redir_flush", 32'(fifo_flush_o), 32'd1);
                    chk("redir_no_push", 32'(fifo_push_o), 32'd0);
                    chk("redir_no_req", 32'(imem_req_o), 32'd0);
                    exp_q.delete();
                    exp_pc = {redirect_pc_i[31:2], 2'b00};
                    occ_m  = 0;
                end else begin
                    chk("flush_idle", 32'(fifo_flush_o), 32'd0);
                    pop_ok = fifo_pop_i && (occ_m > 0);
                    if (imem_req_o) begin
                        chk("req_addr", imem_addr_o, exp_pc);
                        chk("fetch_pc", fetch_pc_o, exp_pc);
                    end
                    if (imem_req_o && imem_gnt_i) begin
                        tmp_r.addr = imem_addr_o;
                        tmp_r.due  = cyc + lat;
                        pending.push_back(tmp_r);
                        exp_q.push_back(mem_word(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        n_gnt++;
                    end
                    if (fifo_push_o) begin
                        n_push++;
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_push: got %h, none expected",
                                     fifo_data_o);
                        end else begin
                            exp_w = exp_q.pop_front();
                            chk("push_data", fifo_data_o, exp_w);
                        end
                        chk("no_overflow", 32'(occ_m < FS), 32'd1);
                        occ_m++;
                    end
                    if (pop_ok)
                        occ_m--;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni        = 1'b0;
        redirect_en_i = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hDEAD_BEEF;
        fifo_pop_i    = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_push", 32'(fifo_push_o), 32'd0);
        chk("rst_flush", 32'(fifo_flush_o), 32'd0);
        chk("rst_addr", imem_addr_o, RSTPC);
        chk("rst_fetch_pc", fetch_pc_o, RSTPC);
        chk("rst_data_pass", fifo_data_o, 32'hDEAD_BEEF);

        // Fill: gnt always, 1-cycle latency, no pops.
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        imem_gnt_i = 1'b1;
        #1 chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        repeat (6) @(posedge clk_i);
        #2 chk("full_no_req", 32'(imem_req_o), 32'd0);
        chk("full_occ", 32'(dut.occ_q), 32'd4);
        g0 = n_gnt;
        @(posedge clk_i);
        #1 fifo_pop_i = 1'b1;
        @(posedge clk_i);
        #1 fifo_pop_i = 1'b0;
        #1 chk("pop_req", 32'(imem_req_o), 32'd1);
        chk("pop_addr", imem_addr_o, 32'h10);
        @(posedge clk_i);
        #2 chk("pop_req_off", 32'(imem_req_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #2 chk("one_req_per_pop", 32'(n_gnt - g0), 32'd1);

        // Steady stream: pop every cycle.
        @(posedge clk_i);
        #1 fifo_pop_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2 p0 = n_push;
        for (int i = 0; i < 8; i++) begin
            chk("steady_occ", 32'(dut.occ_q), 32'd2);
            @(posedge clk_i);
            #2;
        end
        chk("steady_rate", 32'(n_push - p0), 32'd8);

        // Drain, then 4 in flight and redirect.
        #1 imem_gnt_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #1 fifo_pop_i = 1'b0;
        lat = 5;
        imem_gnt_i = 1'b1;
        #1 chk("drained_occ", 32'(dut.occ_q), 32'd0);
        repeat (4) @(posedge clk_i);
        #1 redirect_en_i = 1'b1;
        redirect_pc_i = 32'h0000_1003;
        #1 chk("inflight_live", 32'(dut.live_q), 32'd4);
        chk("redir_flush_pulse", 32'(fifo_flush_o), 32'd1);
        @(posedge clk_i);
        #1 redirect_en_i = 1'b0;
        #1 chk("redir_drop", 32'(dut.drop_q), 32'd4);
        chk("flush_once", 32'(fifo_flush_o), 32'd0);
        for (int i = 0; i < 20 && !imem_req_o; i++) begin
            @(posedge clk_i);
            #2;
        end
        chk("redir_req", 32'(imem_req_o), 32'd1);
        chk("redir_addr", imem_addr_o, 32'h0000_1000);

        // Redirect together with a response and a pop.
        repeat (20) @(posedge clk_i);
        #1 lat = 1;
        fifo_pop_i = 1'b1;
        #1 chk("refill_occ", 32'(dut.occ_q), 32'd4);
        @(posedge clk_i);
        #1 fifo_pop_i = 1'b0;
        @(posedge clk_i);
        #1 redirect_en_i = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        fifo_pop_i = 1'b1;
        #1 chk("redir_rsp_push", 32'(fifo_push_o), 32'd0);
        @(posedge clk_i);
        #1 redirect_en_i = 1'b0;
        fifo_pop_i = 1'b0;
        #1 chk("redir_pop_occ", 32'(dut.occ_q), 32'd0);
        chk("redir_rsp_drop", 32'(dut.drop_q), 32'd0);
        chk("next_cycle_req", 32'(imem_req_o), 32'd1);
        chk("next_cycle_addr", imem_addr_o, 32'h0000_2000);

        // PC wrap.
        @(posedge clk_i);
        #1 imem_gnt_i = 1'b0;
        @(posedge clk_i);
        #1 redirect_en_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        @(posedge clk_i);
        #1 redirect_en_i = 1'b0;
        imem_gnt_i = 1'b1;
        #1 chk("wrap_addr_hi", imem_addr_o, 32'hFFFF_FFFC);
        @(posedge clk_i);
        #1 imem_gnt_i = 1'b0;
        #1 chk("wrap_addr_lo", imem_addr_o, 32'h0);

        // Spurious response.
        @(posedge clk_i);
        #2 force_rv = 1'b1;
        @(posedge clk_i);
        #2 chk("spur_no_push", 32'(fifo_push_o), 32'd0);
        force_rv = 1'b0;
        @(posedge clk_i);
        #2 chk("spur_occ", 32'(dut.occ_q), 32'd1);
        chk("spur_live", 32'(dut.live_q), 32'd0);
        chk("spur_drop", 32'(dut.drop_q), 32'd0);

        // Reset mid-stream with two entries buffered.
        @(posedge clk_i);
        #1 imem_gnt_i = 1'b1;
        @(posedge clk_i);
        #1 imem_gnt_i = 1'b0;
        @(posedge clk_i);
        #2 chk("pre_rst_occ", 32'(dut.occ_q), 32'd2);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        imem_gnt_i = 1'b1;
        #1 chk("mid_rst_req", 32'(imem_req_o), 32'd0);
        chk("mid_rst_push", 32'(fifo_push_o), 32'd0);
        chk("mid_rst_flush", 32'(fifo_flush_o), 32'd0);
        chk("mid_rst_pc", fetch_pc_o, RSTPC);
        chk("mid_rst_occ", 32'(dut.occ_q), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1 chk("post_rst_req", 32'(imem_req_o), 32'd1);
        chk("post_rst_addr", imem_addr_o, RSTPC);
        chk("post_rst_occ", 32'(dut.occ_q), 32'd0);
        repeat (8) @(posedge clk_i);
        #1 imem_gnt_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 chk("final_occ", 32'(dut.occ_q), 32'd4);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
